// File: rtl/fifo_v3.sv
// Synchronous FIFO with occupancy count, synchronous flush and optional fall-through.
// DEPTH == 0 turns the block into a combinational pass-through with no storage.
// Optional macro FIFO_ASSERT_EN compiles in simulation-only usage checks.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  // Keep at least one memory word so the DEPTH == 0 build still elaborates.
  localparam int unsigned           MemDepth = (DEPTH > 0) ? DEPTH : 1;
  localparam logic [ADDR_DEPTH-1:0] LastPtr  = ADDR_DEPTH'(MemDepth - 1);
  localparam logic [ADDR_DEPTH-1:0] PtrOne   = 1;
  localparam logic [ADDR_DEPTH:0]   CntOne   = 1;
  localparam logic [ADDR_DEPTH:0]   FullCnt  = (ADDR_DEPTH + 1)'(DEPTH);

  logic [ADDR_DEPTH-1:0] r_rptr, r_wptr;
  logic [ADDR_DEPTH-1:0] w_rptr_nxt, w_wptr_nxt;
  logic [ADDR_DEPTH:0]   r_cnt, w_cnt_nxt;
  logic                  w_we;
  dtype                  r_mem [MemDepth];

  // testmode_i has no functional effect.
  logic w_unused_testmode;
  assign w_unused_testmode = testmode_i;

  // Flags, head data and next pointer/count state.
  always_comb begin
    w_rptr_nxt = r_rptr;
    w_wptr_nxt = r_wptr;
    w_cnt_nxt  = r_cnt;
    w_we       = 1'b0;
    full_o     = (r_cnt == FullCnt);
    empty_o    = (r_cnt == '0) & ~(FALL_THROUGH & push_i);
    usage_o    = r_cnt[ADDR_DEPTH-1:0];
    data_o     = r_mem[r_rptr];

    if (push_i && !full_o) begin
      w_we       = 1'b1;
      w_wptr_nxt = (r_wptr == LastPtr) ? '0 : r_wptr + PtrOne;
      w_cnt_nxt  = r_cnt + CntOne;
    end
    // Decrement from the push-adjusted count so a simultaneous push and pop nets to zero.
    if (pop_i && !empty_o) begin
      w_rptr_nxt = (r_rptr == LastPtr) ? '0 : r_rptr + PtrOne;
      w_cnt_nxt  = w_cnt_nxt - CntOne;
    end

    // Bypass: an empty FIFO shows the incoming word; if it is popped at once nothing is stored.
    if (FALL_THROUGH && (r_cnt == '0) && push_i) begin
      data_o = data_i;
      if (pop_i) begin
        w_rptr_nxt = r_rptr;
        w_wptr_nxt = r_wptr;
        w_cnt_nxt  = r_cnt;
        w_we       = 1'b0;
      end
    end

    // Flush wins over any push or pop in the same cycle; memory is left as is.
    if (flush_i) begin
      w_rptr_nxt = '0;
      w_wptr_nxt = '0;
      w_cnt_nxt  = '0;
      w_we       = 1'b0;
    end

    if (DEPTH == 0) begin
      data_o     = data_i;
      empty_o    = ~push_i;
      full_o     = ~pop_i;
      usage_o    = '0;
      w_rptr_nxt = '0;
      w_wptr_nxt = '0;
      w_cnt_nxt  = '0;
      w_we       = 1'b0;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else begin
      r_rptr <= w_rptr_nxt;
      r_wptr <= w_wptr_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Storage array, cleared on reset only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem <= '{default: '0};
    end else if (w_we) begin
      r_mem[r_wptr] <= data_i;
    end
  end

`ifdef FIFO_ASSERT_EN
`ifndef SYNTHESIS
  if (DEPTH > 0 && DATA_WIDTH == 0) begin : g_width_check
    $fatal(1, "fifo_v3: DATA_WIDTH must be non-zero when DEPTH > 0");
  end

  // Flag handshake misuse by the surrounding logic.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (push_i && full_o && !(DEPTH == 0 && pop_i)) begin
        $error("fifo_v3: push while full");
      end
      if (pop_i && empty_o) begin
        $error("fifo_v3: pop while empty");
      end
    end
  end
`endif
`else
  // Usage checks not compiled in.
`endif

endmodule

// File: tb/tb_fifo_v3.sv
// Bench for fifo_v3: registered (DEPTH 4), fall-through (DEPTH 4) and pass-through (DEPTH 0)
// instances, directed scenarios plus random traffic against a queue model.
module tb_fifo_v3;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  typedef logic [W-1:0] q_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Index 0: registered, 1: fall-through, 2: DEPTH 0.
  logic [2:0]        flush, push, pop, full, empty;
  logic [2:0][W-1:0] din, dout;
  logic [1:0][1:0]   usage;
  logic              usage_z;

  int n_cmp;
  int n_fail;

  q_t q0, q1;

  fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(W), .DEPTH(D)) u_fifo_reg (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[0]), .testmode_i(1'b0),
    .full_o(full[0]), .empty_o(empty[0]), .usage_o(usage[0]),
    .data_i(din[0]), .push_i(push[0]), .data_o(dout[0]), .pop_i(pop[0])
  );

  fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(W), .DEPTH(D)) u_fifo_ft (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[1]), .testmode_i(1'b0),
    .full_o(full[1]), .empty_o(empty[1]), .usage_o(usage[1]),
    .data_i(din[1]), .push_i(push[1]), .data_o(dout[1]), .pop_i(pop[1])
  );

  fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(W), .DEPTH(0)) u_fifo_zero (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[2]), .testmode_i(1'b0),
    .full_o(full[2]), .empty_o(empty[2]), .usage_o(usage_z),
    .data_i(din[2]), .push_i(push[2]), .data_o(dout[2]), .pop_i(pop[2])
  );

  // Reference behaviour at a clock edge for the DEPTH 4 instances.
  task automatic model_edge(input int k);
    q_t q;
    int n;
    bit ft;
    if (k > 1) return;
    if (k == 0) q = q0; else q = q1;
    n  = q.size();
    ft = (k == 1);
    if (flush[k]) begin
      q.delete();
    end else if (!(ft && n == 0 && push[k] && pop[k])) begin
      if (pop[k] && n > 0) void'(q.pop_front());
      if (push[k] && n < int'(D)) q.push_back(din[k]);
    end
    if (k == 0) q0 = q; else q1 = q;
  endtask

  task automatic drive(input int k, input logic pu, input logic po, input logic fl,
                       input logic [W-1:0] d);
    push[k]  = pu;
    pop[k]   = po;
    flush[k] = fl;
    din[k]   = d;
    #1;
  endtask

  task automatic advance(input int k);
    model_edge(k);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    flush = '0; push = '0; pop = '0; din = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (empty[k] !== 1'b1) begin n_fail++; $display("FAIL reset_empty[%0d]: got %b want 1", k, empty[k]); end
      n_cmp++; if (full[k] !== 1'b0) begin n_fail++; $display("FAIL reset_full[%0d]: got %b want 0", k, full[k]); end
      n_cmp++; if (usage[k] !== 2'd0) begin n_fail++; $display("FAIL reset_usage[%0d]: got %0d want 0", k, usage[k]); end
      n_cmp++; if (dout[k] !== '0) begin n_fail++; $display("FAIL reset_data[%0d]: got %h want 00", k, dout[k]); end
    end
    n_cmp++; if (empty[2] !== 1'b1 || full[2] !== 1'b1 || usage_z !== 1'b0)
      begin n_fail++; $display("FAIL reset_zero_flags: got e%b f%b u%b want e1 f1 u0", empty[2], full[2], usage_z); end
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] vals[4];
    vals = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 1'b0, 1'b0, vals[i]);
      n_cmp++; if (usage[0] !== 2'(i)) begin n_fail++; $display("FAIL fill_usage: got %0d want %0d", usage[0], i); end
      if (i > 0) begin
        n_cmp++; if (dout[0] !== 8'h0A) begin n_fail++; $display("FAIL fill_head: got %h want 0a", dout[0]); end
      end
      advance(0);
    end
    drive(0, 1'b1, 1'b0, 1'b0, 8'h0E);
    n_cmp++; if (full[0] !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", full[0]); end
    n_cmp++; if (usage[0] !== 2'd0) begin n_fail++; $display("FAIL full_usage_wrap: got %0d want 0", usage[0]); end
    advance(0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, 1'b1, 1'b0, 8'h00);
      n_cmp++; if (dout[0] !== vals[i]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, dout[0], vals[i]); end
      advance(0);
    end
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    n_cmp++; if (empty[0] !== 1'b1 || full[0] !== 1'b0)
      begin n_fail++; $display("FAIL drained_flags: got e%b f%b want e1 f0", empty[0], full[0]); end
  endtask

  task automatic test_fall_through();
    drive(1, 1'b0, 1'b0, 1'b1, 8'h00);
    advance(1);
    drive(1, 1'b1, 1'b1, 1'b0, 8'h55);
    n_cmp++; if (dout[1] !== 8'h55) begin n_fail++; $display("FAIL ft_bypass_data: got %h want 55", dout[1]); end
    n_cmp++; if (empty[1] !== 1'b0) begin n_fail++; $display("FAIL ft_bypass_empty: got %b want 0", empty[1]); end
    advance(1);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    n_cmp++; if (usage[1] !== 2'd0 || empty[1] !== 1'b1)
      begin n_fail++; $display("FAIL ft_after_bypass: got u%0d e%b want u0 e1", usage[1], empty[1]); end
    drive(1, 1'b1, 1'b0, 1'b0, 8'h66);
    n_cmp++; if (dout[1] !== 8'h66) begin n_fail++; $display("FAIL ft_push_data: got %h want 66", dout[1]); end
    advance(1);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    n_cmp++; if (usage[1] !== 2'd1 || dout[1] !== 8'h66)
      begin n_fail++; $display("FAIL ft_stored: got u%0d d%h want u1 d66", usage[1], dout[1]); end
  endtask

  task automatic test_full_push_pop();
    drive(0, 1'b0, 1'b0, 1'b1, 8'h00);
    advance(0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
      advance(0);
    end
    drive(0, 1'b1, 1'b1, 1'b0, 8'h99);
    n_cmp++; if (full[0] !== 1'b1 || dout[0] !== 8'h20)
      begin n_fail++; $display("FAIL full_pp_before: got f%b d%h want f1 d20", full[0], dout[0]); end
    advance(0);
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    n_cmp++; if (full[0] !== 1'b0 || usage[0] !== 2'd3 || dout[0] !== 8'h21)
      begin n_fail++; $display("FAIL full_pp_after: got f%b u%0d d%h want f0 u3 d21", full[0], usage[0], dout[0]); end
  endtask

  task automatic test_back_to_back();
    drive(0, 1'b0, 1'b0, 1'b1, 8'h00);
    advance(0);
    drive(0, 1'b1, 1'b0, 1'b0, 8'h40);
    advance(0);
    drive(0, 1'b1, 1'b0, 1'b0, 8'h41);
    advance(0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b1, 1'b1, 1'b0, 8'(8'h42 + i));
      n_cmp++; if (usage[0] !== 2'd2 || dout[0] !== 8'(8'h40 + i))
        begin n_fail++; $display("FAIL b2b[%0d]: got u%0d d%h want u2 d%h", i, usage[0], dout[0], 8'(8'h40 + i)); end
      advance(0);
    end
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    n_cmp++; if (usage[0] !== 2'd2 || dout[0] !== 8'h4A)
      begin n_fail++; $display("FAIL b2b_end: got u%0d d%h want u2 d4a", usage[0], dout[0]); end
  endtask

  task automatic test_flush();
    drive(0, 1'b0, 1'b0, 1'b1, 8'h00);
    advance(0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 1'b0, 1'b0, 8'(8'h70 + i));
      advance(0);
    end
    drive(0, 1'b1, 1'b0, 1'b1, 8'h77);
    advance(0);
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    n_cmp++; if (empty[0] !== 1'b1 || usage[0] !== 2'd0)
      begin n_fail++; $display("FAIL flush: got e%b u%0d want e1 u0", empty[0], usage[0]); end
  endtask

  task automatic test_depth0();
    drive(2, 1'b1, 1'b1, 1'b0, 8'h03);
    n_cmp++; if (dout[2] !== 8'h03 || empty[2] !== 1'b0 || full[2] !== 1'b0 || usage_z !== 1'b0)
      begin n_fail++; $display("FAIL zero_pp: got d%h e%b f%b u%b want d03 e0 f0 u0", dout[2], empty[2], full[2], usage_z); end
    advance(2);
    drive(2, 1'b0, 1'b0, 1'b0, 8'h5A);
    n_cmp++; if (dout[2] !== 8'h5A || empty[2] !== 1'b1 || full[2] !== 1'b1)
      begin n_fail++; $display("FAIL zero_idle: got d%h e%b f%b want d5a e1 f1", dout[2], empty[2], full[2]); end
    drive(2, 1'b1, 1'b0, 1'b0, 8'hC3);
    n_cmp++; if (dout[2] !== 8'hC3 || empty[2] !== 1'b0 || full[2] !== 1'b1)
      begin n_fail++; $display("FAIL zero_push: got d%h e%b f%b want dc3 e0 f1", dout[2], empty[2], full[2]); end
    drive(2, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_random(input int k);
    q_t          q;
    int          n;
    logic        pu, po, fl;
    logic [W-1:0] d;
    drive(k, 1'b0, 1'b0, 1'b1, 8'h00);
    advance(k);
    for (int i = 0; i < 400; i++) begin
      // Alternate fill-biased and drain-biased phases to reach both full and empty.
      pu = ($urandom_range(0, 99) < (((i / 40) % 2) ? 75 : 30));
      po = ($urandom_range(0, 99) < (((i / 40) % 2) ? 30 : 75));
      fl = ($urandom_range(0, 99) < 2);
      d  = W'($urandom);
      drive(k, pu, po, fl, d);
      if (k == 0) q = q0; else q = q1;
      n = q.size();
      n_cmp++; if (full[k] !== (n == int'(D)))
        begin n_fail++; $display("FAIL rand_full[%0d] cyc %0d: got %b want %b", k, i, full[k], (n == int'(D))); end
      n_cmp++; if (empty[k] !== ((n == 0) && !(k == 1 && pu)))
        begin n_fail++; $display("FAIL rand_empty[%0d] cyc %0d: got %b want %b", k, i, empty[k], ((n == 0) && !(k == 1 && pu))); end
      n_cmp++; if (usage[k] !== 2'(n))
        begin n_fail++; $display("FAIL rand_usage[%0d] cyc %0d: got %0d want %0d", k, i, usage[k], 2'(n)); end
      if (k == 1 && n == 0 && pu) begin
        n_cmp++; if (dout[k] !== d)
          begin n_fail++; $display("FAIL rand_bypass[%0d] cyc %0d: got %h want %h", k, i, dout[k], d); end
      end else if (n > 0) begin
        n_cmp++; if (dout[k] !== q[0])
          begin n_fail++; $display("FAIL rand_head[%0d] cyc %0d: got %h want %h", k, i, dout[k], q[0]); end
      end
      advance(k);
    end
    drive(k, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_fill_drain();
    test_fall_through();
    test_full_push_pop();
    test_back_to_back();
    test_flush();
    test_depth0();
    test_random(0);
    test_random(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
